uart_rx_frame_ctrl: RTL and testbench

//  Frame-level controller for the UART receive path. Detects the start edge on RX_IN and runs the

---
 rtl/uart_rx_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Frame-level controller for the UART receive path. It detects the start
//   edge, runs the oversampling edge counter and the bit counter that steer
//   the external 3-sample majority sampler, and checks the start, parity and
//   stop bits. Data bits are deserialised LSB-first. The received word is
//   presented with a one-cycle data_valid pulse.
//
//   Optional build macro: RX_ERR_CNT_EN
//     When defined, the block adds the err_clr input and a saturating 8-bit
//     err_cnt output. The counter counts par_err/stp_err pulses.
//     When undefined, neither port nor any counter logic exists.
// ----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6,
    parameter int EDGE_W     = 5
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
`ifdef RX_ERR_CNT_EN
    input  logic                  err_clr,
    output logic [7:0]            err_cnt,
`endif
    output logic                  data_samp_en,
    output logic [EDGE_W-1:0]     edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    // Legal oversampling ratios. Any other value falls back to 8.
    localparam logic [PRESC_W-1:0] C_PRESC_8  = PRESC_W'(8);
    localparam logic [PRESC_W-1:0] C_PRESC_16 = PRESC_W'(16);
    localparam logic [PRESC_W-1:0] C_PRESC_32 = PRESC_W'(32);

    // The bit counter value at which the final data bit ends (start bit = 0).
    localparam logic [3:0] C_LAST_DATA_BIT = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [EDGE_W-1:0]   r_last;          // latched prescale - 1 for this frame
    logic                r_par_en;        // latched PAR_EN for this frame
    logic                r_par_typ;       // latched PAR_TYP for this frame
    logic                r_frame_par_err; // parity failed somewhere in this frame

    logic [EDGE_W-1:0]   w_last_in;
    logic                w_bit_end;
    logic                w_exp_par;
    logic [EDGE_W-1:0]   w_edge_inc;
    logic [3:0]          w_bit_inc;

    // Map the prescale input to the last edge index; illegal ratios act like 8.
    function automatic logic [EDGE_W-1:0] last_edge_of(input logic [PRESC_W-1:0] presc);
        logic [EDGE_W-1:0] last;
        case (presc)
            C_PRESC_8:  last = EDGE_W'(7);
            C_PRESC_16: last = EDGE_W'(15);
            C_PRESC_32: last = EDGE_W'(31);
            default:    last = EDGE_W'(7);
        endcase
        return last;
    endfunction

    // Parity bit the line must carry for a word: even parity when typ=0, odd when typ=1.
    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] word,
                                             input logic                  typ);
        return (^word) ^ typ;
    endfunction

    // Bit-end strobe, expected parity and counter increments for the FSM.
    always_comb begin
        w_last_in  = last_edge_of(prescale);
        w_exp_par  = expected_parity(P_DATA, r_par_typ);
        w_edge_inc = edge_cnt + EDGE_W'(1);
        w_bit_inc  = bit_cnt + 4'd1;
        if (r_state != ST_IDLE) begin
            w_bit_end = (edge_cnt == r_last);
        end else begin
            w_bit_end = 1'b0;
        end
    end

    // Frame FSM with counters, shift register and registered one-cycle flags.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state         <= ST_IDLE;
            r_last          <= EDGE_W'(7);
            r_par_en        <= 1'b0;
            r_par_typ       <= 1'b0;
            r_frame_par_err <= 1'b0;
            data_samp_en    <= 1'b0;
            edge_cnt        <= '0;
            bit_cnt         <= 4'd0;
            P_DATA          <= '0;
            data_valid      <= 1'b0;
            par_err         <= 1'b0;
            stp_err         <= 1'b0;
        end else begin
            // Flags are pulses: they drop unless set again below.
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= 4'd0;
                    if (!RX_IN) begin
                        // Start edge: freeze the frame configuration.
                        r_state         <= ST_START;
                        r_last          <= w_last_in;
                        r_par_en        <= PAR_EN;
                        r_par_typ       <= PAR_TYP;
                        r_frame_par_err <= 1'b0;
                        data_samp_en    <= 1'b1;
                    end else begin
                        data_samp_en <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        edge_cnt <= '0;
                        if (!sampled_bit) begin
                            r_state <= ST_DATA;
                            bit_cnt <= w_bit_inc;
                        end else begin
                            // A short low pulse on the line: drop it silently.
                            r_state      <= ST_IDLE;
                            bit_cnt      <= 4'd0;
                            data_samp_en <= 1'b0;
                        end
                    end else begin
                        edge_cnt <= w_edge_inc;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        edge_cnt <= '0;
                        bit_cnt  <= w_bit_inc;
                        P_DATA   <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
                        if (bit_cnt == C_LAST_DATA_BIT) begin
                            if (r_par_en) begin
                                r_state <= ST_PARITY;
                            end else begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        edge_cnt <= w_edge_inc;
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        edge_cnt <= '0;
                        bit_cnt  <= w_bit_inc;
                        r_state  <= ST_STOP;
                        if (sampled_bit != w_exp_par) begin
                            par_err         <= 1'b1;
                            r_frame_par_err <= 1'b1;
                        end else begin
                            r_frame_par_err <= r_frame_par_err;
                        end
                    end else begin
                        edge_cnt <= w_edge_inc;
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        // Return to IDLE so the next start bit can be seen one cycle later.
                        r_state      <= ST_IDLE;
                        edge_cnt     <= '0;
                        bit_cnt      <= 4'd0;
                        data_samp_en <= 1'b0;
                        stp_err      <= ~sampled_bit;
                        data_valid   <= sampled_bit & ~r_frame_par_err;
                    end else begin
                        edge_cnt <= w_edge_inc;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    edge_cnt     <= '0;
                    bit_cnt      <= 4'd0;
                    data_samp_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_ERR_CNT_EN
    // Saturating error counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (RST) begin
            err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_cnt <= 8'd0;
        end else if ((par_err || stp_err) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end else begin
            err_cnt <= err_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for uart_rx_frame_ctrl. A line driver sends whole UART frames, a
// 3-sample majority sampler stands in for the real data sampler, and a
// frame-level model predicts the flag/data records each frame must produce.
// Build with +define+RX_ERR_CNT_EN to also exercise the error counter.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       data_samp_en;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
`ifdef RX_ERR_CNT_EN
    logic       err_clr;
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_presc = 8;
    int last_gap = 1;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        int         cyc;
    } rec_t;

    rec_t mon_q[$];
    rec_t exp_q[$];

    always #5 clk = ~clk;

    uart_rx_frame_ctrl dut (
        .clk          (clk),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
`ifdef RX_ERR_CNT_EN
        .err_clr      (err_clr),
        .err_cnt      (err_cnt),
`endif
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Sampler stand-in: three samples around mid-bit, cleared while disabled.
    logic [2:0] r_samp;
    always @(posedge clk) begin
        if (data_samp_en !== 1'b1) begin
            r_samp <= 3'b000;
        end else begin
            if (int'(edge_cnt) == cur_presc / 2 - 1) r_samp[0] <= RX_IN;
            if (int'(edge_cnt) == cur_presc / 2)     r_samp[1] <= RX_IN;
            if (int'(edge_cnt) == cur_presc / 2 + 1) r_samp[2] <= RX_IN;
        end
    end
    assign sampled_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

    // Monitor: every cycle with a flag high becomes one record.
    always @(negedge clk) begin
        if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1) begin
            rec_t r;
            r.dv   = data_valid;
            r.pe   = par_err;
            r.se   = stp_err;
            r.data = (data_valid === 1'b1) ? P_DATA : 8'h00;
            r.cyc  = cyc;
            mon_q.push_back(r);
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame on the line and queue the records the model predicts.
    task automatic send_frame(input logic [5:0] p_in, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pbad, input logic sbad);
        int   eff;
        logic good_par;
        rec_t e;
        if (p_in == 6'd16 || p_in == 6'd32) eff = int'(p_in);
        else eff = 8;
        prescale  = p_in;
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        cur_presc = eff;
        good_par  = (($countones(d) % 2) == 1) ^ ptyp;
        RX_IN = 1'b0;
        repeat (eff) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (eff) @(negedge clk);
        end
        if (pen) begin
            RX_IN = good_par ^ pbad;
            repeat (eff) @(negedge clk);
        end
        RX_IN = ~sbad;
        repeat (eff) @(negedge clk);
        RX_IN = 1'b1;
        e.cyc = 0;
        if (pen && pbad) begin
            e.dv = 1'b0; e.pe = 1'b1; e.se = 1'b0; e.data = 8'h00;
            exp_q.push_back(e);
        end
        if (sbad) begin
            e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1; e.data = 8'h00;
            exp_q.push_back(e);
        end else if (!(pen && pbad)) begin
            e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0; e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_samp_en, edge_cnt, bit_cnt} !== 10'd0)
            begin errors++; $display("FAIL reset_ctrl got %b required 0", {data_samp_en, edge_cnt, bit_cnt}); end
        checks++;
        if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata got %h required 00", P_DATA); end
        checks++;
        if ({data_valid, par_err, stp_err} !== 3'b000)
            begin errors++; $display("FAIL reset_flags got %b required 000", {data_valid, par_err, stp_err}); end
        RST = 1'b0;
        idle(4);
        mon_q.delete();
    endtask

    task automatic test_8n1;
        int c0;
        c0 = cyc;
        send_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        exp_q.delete();
        checks++;
        if (mon_q.size() != 1) begin
            errors++; $display("FAIL 8n1_records got %0d required 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0].dv !== 1'b1 || mon_q[0].data !== 8'hA5 || mon_q[0].pe !== 1'b0 || mon_q[0].se !== 1'b0) begin
                errors++; $display("FAIL 8n1_word got dv=%b pe=%b se=%b data=%h required dv=1 pe=0 se=0 data=a5",
                                   mon_q[0].dv, mon_q[0].pe, mon_q[0].se, mon_q[0].data);
            end
            checks++;
            if (mon_q[0].cyc != c0 + 10 * 8 + 1) begin
                errors++; $display("FAIL 8n1_latency got cycle %0d required %0d", mon_q[0].cyc, c0 + 81);
            end
        end
        mon_q.delete();
    endtask

    // Directed frames whose records go through the common queue compare.
    task automatic test_parity_stop;
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        send_frame(6'd16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        send_frame(6'd32, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        send_frame(6'd32, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_frame(6'd12, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);
        send_frame(6'd12, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        checks++;
        if (mon_q.size() != exp_q.size())
            begin errors++; $display("FAIL dir_count got %0d required %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (mon_q[i].dv !== exp_q[i].dv || mon_q[i].pe !== exp_q[i].pe ||
                mon_q[i].se !== exp_q[i].se || mon_q[i].data !== exp_q[i].data) begin
                errors++; $display("FAIL dir_rec%0d got dv=%b pe=%b se=%b d=%h required dv=%b pe=%b se=%b d=%h", i,
                    mon_q[i].dv, mon_q[i].pe, mon_q[i].se, mon_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].data);
            end
        end
        mon_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch;
        prescale = 6'd8; PAR_EN = 1'b0; cur_presc = 8;
        RX_IN = 1'b0;
        @(negedge clk);
        checks++;
        if (data_samp_en !== 1'b1 || edge_cnt !== 5'd0)
            begin errors++; $display("FAIL glitch_start got en=%b edge=%0d required en=1 edge=0", data_samp_en, edge_cnt); end
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (edge_cnt !== 5'd7 || data_samp_en !== 1'b1)
            begin errors++; $display("FAIL glitch_edge got edge=%0d en=%b required edge=7 en=1", edge_cnt, data_samp_en); end
        @(negedge clk);
        checks++;
        if (data_samp_en !== 1'b0 || bit_cnt !== 4'd0 || edge_cnt !== 5'd0)
            begin errors++; $display("FAIL glitch_abort got en=%b bit=%0d edge=%0d required 0 0 0", data_samp_en, bit_cnt, edge_cnt); end
        idle(20);
        checks++;
        if (mon_q.size() != 0) begin errors++; $display("FAIL glitch_flags got %0d records required 0", mon_q.size()); end
        mon_q.delete();
    endtask

    task automatic test_midframe_reset;
        logic [7:0] d;
        d = 8'hF5;
        prescale = 6'd8; PAR_EN = 1'b0; cur_presc = 8;
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin RX_IN = d[i]; repeat (8) @(negedge clk); end
        RX_IN = d[4];
        repeat (3) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_samp_en, edge_cnt, bit_cnt, P_DATA, data_valid, par_err, stp_err} !== 21'd0)
            begin errors++; $display("FAIL midreset_outputs got %h required 0",
                  {data_samp_en, edge_cnt, bit_cnt, P_DATA, data_valid, par_err, stp_err}); end
        RST = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 5; i < 8; i++) begin RX_IN = d[i]; repeat (8) @(negedge clk); end
        RX_IN = 1'b1;
        idle(12);
        checks++;
        if (mon_q.size() != 0) begin errors++; $display("FAIL midreset_flags got %0d records required 0", mon_q.size()); end
        mon_q.delete();
        send_frame(6'd8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (mon_q.size() != 1 || mon_q[0].dv !== 1'b1 || mon_q[0].data !== 8'h81)
            begin errors++; $display("FAIL midreset_next got %0d records required one 81 word", mon_q.size()); end
        mon_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(6'd16, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(6'd16, 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        send_frame(6'd8, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(6'd8, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);
        checks++;
        if (mon_q.size() != exp_q.size())
            begin errors++; $display("FAIL b2b_count got %0d required %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (mon_q[i].dv !== exp_q[i].dv || mon_q[i].data !== exp_q[i].data ||
                mon_q[i].pe !== exp_q[i].pe || mon_q[i].se !== exp_q[i].se)
                begin errors++; $display("FAIL b2b_rec%0d got dv=%b d=%h required dv=%b d=%h", i,
                      mon_q[i].dv, mon_q[i].data, exp_q[i].dv, exp_q[i].data); end
        end
        mon_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        logic [5:0] p;
        int gap;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: p = 6'd8;
                1: p = 6'd16;
                2: p = 6'd32;
                default: p = 6'(4 + 4 * $urandom_range(0, 6));
            endcase
            send_frame(p, 8'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            gap = (last_gap == 0) ? 2 : $urandom_range(0, 2);
            last_gap = gap;
            idle(gap);
        end
        idle(10);
        checks++;
        if (mon_q.size() != exp_q.size())
            begin errors++; $display("FAIL rand_count got %0d required %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (mon_q[i].dv !== exp_q[i].dv || mon_q[i].pe !== exp_q[i].pe ||
                mon_q[i].se !== exp_q[i].se || mon_q[i].data !== exp_q[i].data)
                begin errors++; $display("FAIL rand_rec%0d got dv=%b pe=%b se=%b d=%h required dv=%b pe=%b se=%b d=%h", i,
                      mon_q[i].dv, mon_q[i].pe, mon_q[i].se, mon_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].data); end
        end
        mon_q.delete(); exp_q.delete();
    endtask

`ifdef RX_ERR_CNT_EN
    task automatic test_err_cnt;
        logic seen;
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_reset got %0d required 0", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            send_frame(6'd8, 8'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b1, 1'b0);
            idle(3);
        end
        idle(4);
        checks++;
        if (err_cnt !== 8'd3) begin errors++; $display("FAIL errcnt_three got %0d required 3", err_cnt); end
        seen = 1'b0;
        fork
            send_frame(6'd8, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
            begin
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge clk);
                    if (par_err === 1'b1) begin
                        seen = 1'b1;
                        err_clr = 1'b1;
                        @(negedge clk);
                        err_clr = 1'b0;
                        checks++;
                        if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_clr_prio got %0d required 0", err_cnt); end
                    end
                end
            end
        join
        checks++;
        if (!seen) begin errors++; $display("FAIL errcnt_pulse got no par_err required one"); end
        idle(6);
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_hold got %0d required 0", err_cnt); end
        mon_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        RST = 1'b1; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
`ifdef RX_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity_stop();
        test_glitch();
        test_midframe_reset();
        test_back_to_back();
        test_random();
`ifdef RX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
